// File: rtl/multi_freq_serial_ch.sv
// Single-channel serial pattern engine: shifts a DATA_BIT pattern out LSB first,
// holding each bit for a per-bit selectable period, with one-shot/continuous/repeat modes.
module multi_freq_serial_ch #(
    parameter int DATA_BIT     = 32,
    parameter int SEL_BIT      = 2,
    parameter int PERIOD_WIDTH = 8,
    parameter int REPEAT_WIDTH = 8
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic [DATA_BIT-1:0]                      data_i,
    input  logic [DATA_BIT*SEL_BIT-1:0]              freq_sel_i,
    input  logic [(2**SEL_BIT)*PERIOD_WIDTH-1:0]     period_i,
    input  logic [1:0]                               mode_i,
    input  logic [REPEAT_WIDTH-1:0]                  repeat_i,
    input  logic                                     idle_level_i,
    input  logic                                     start_i,
    input  logic                                     stop_i,
    output logic                                     serial_o,
    output logic                                     busy_o,
    output logic                                     bit_tick_o,
    output logic                                     done_tick_o
);
    localparam int SLOTS = 2 ** SEL_BIT;
    localparam int BW    = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BIT - 1);

    typedef enum logic {S_IDLE, S_RUN} state_e;

    state_e                             state_q, state_d;
    logic [DATA_BIT-1:0]                data_q, data_d;
    logic [DATA_BIT*SEL_BIT-1:0]        sel_q, sel_d;
    logic [SLOTS*PERIOD_WIDTH-1:0]      period_q, period_d;
    logic [1:0]                         mode_q, mode_d;
    logic [REPEAT_WIDTH-1:0]            rep_q, rep_d;
    logic                               idle_q, idle_d;
    logic [BW-1:0]                      b_q, b_d;
    logic [PERIOD_WIDTH-1:0]            c_q, c_d;
    logic [REPEAT_WIDTH-1:0]            p_q, p_d;
    logic                               serial_q, serial_d;
    logic                               busy_q, busy_d;
    logic                               bit_tick_q, bit_tick_d;
    logic                               done_q, done_d;

    logic [PERIOD_WIDTH-1:0]            cur_len, len_d;
    logic [REPEAT_WIDTH-1:0]            p_inc, rep_max;
    logic                               last_pass;

    // A zero period is stretched to one cycle so every bit is visible.
    function automatic logic [PERIOD_WIDTH-1:0] bit_len(
        input logic [SLOTS*PERIOD_WIDTH-1:0] per,
        input logic [SEL_BIT-1:0]            s
    );
        logic [PERIOD_WIDTH-1:0] v;
        v = per[int'(s)*PERIOD_WIDTH +: PERIOD_WIDTH];
        return (v == '0) ? PERIOD_WIDTH'(1) : v;
    endfunction

    assign cur_len = bit_len(period_q, sel_q[int'(b_q)*SEL_BIT +: SEL_BIT]);
    assign p_inc   = (p_q == '1) ? p_q : p_q + 1'b1;
    assign rep_max = (rep_q == '0) ? REPEAT_WIDTH'(1) : rep_q;

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        sel_d     = sel_q;
        period_d  = period_q;
        mode_d    = mode_q;
        rep_d     = rep_q;
        idle_d    = idle_q;
        b_d       = b_q;
        c_d       = c_q;
        p_d       = p_q;
        serial_d  = serial_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        last_pass = 1'b1;
        case (state_q)
            S_IDLE: begin
                serial_d = idle_level_i;
                busy_d   = 1'b0;
                if (start_i && !stop_i) begin
                    data_d   = data_i;
                    sel_d    = freq_sel_i;
                    period_d = period_i;
                    mode_d   = mode_i;
                    rep_d    = repeat_i;
                    idle_d   = idle_level_i;
                    b_d      = '0;
                    c_d      = '0;
                    p_d      = '0;
                    state_d  = S_RUN;
                    busy_d   = 1'b1;
                    serial_d = data_i[0];
                end
            end
            S_RUN: begin
                if (stop_i) begin
                    state_d  = S_IDLE;
                    serial_d = idle_q;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                end else if (c_q == cur_len - 1'b1) begin
                    c_d = '0;
                    if (b_q == LAST_BIT) begin
                        b_d = '0;
                        case (mode_q)
                            2'b01:   last_pass = 1'b0;
                            2'b10: begin
                                p_d       = p_inc;
                                last_pass = (p_inc >= rep_max);
                            end
                            default: last_pass = 1'b1;
                        endcase
                        if (last_pass) begin
                            state_d  = S_IDLE;
                            serial_d = idle_q;
                            busy_d   = 1'b0;
                            done_d   = 1'b1;
                        end else begin
                            serial_d = data_q[0];
                        end
                    end else begin
                        b_d      = b_q + 1'b1;
                        serial_d = data_q[b_d];
                    end
                end else begin
                    c_d = c_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // The tick is registered, so it is predicted from the state about to be shown.
        len_d      = bit_len(period_d, sel_d[int'(b_d)*SEL_BIT +: SEL_BIT]);
        bit_tick_d = (state_d == S_RUN) && (c_d == len_d - 1'b1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            data_q     <= '0;
            sel_q      <= '0;
            period_q   <= '0;
            mode_q     <= '0;
            rep_q      <= '0;
            idle_q     <= 1'b0;
            b_q        <= '0;
            c_q        <= '0;
            p_q        <= '0;
            serial_q   <= 1'b0;
            busy_q     <= 1'b0;
            bit_tick_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            sel_q      <= sel_d;
            period_q   <= period_d;
            mode_q     <= mode_d;
            rep_q      <= rep_d;
            idle_q     <= idle_d;
            b_q        <= b_d;
            c_q        <= c_d;
            p_q        <= p_d;
            serial_q   <= serial_d;
            busy_q     <= busy_d;
            bit_tick_q <= bit_tick_d;
            done_q     <= done_d;
        end
    end

    assign serial_o    = serial_q;
    assign busy_o      = busy_q;
    assign bit_tick_o  = bit_tick_q;
    assign done_tick_o = done_q;
endmodule

// File: tb/tb_multi_freq_serial_ch.sv
// Directed self-checking bench for multi_freq_serial_ch with a per-cycle bit-length model.
module tb_multi_freq_serial_ch;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] data;
    logic [63:0] fsel;
    logic [31:0] period;
    logic [1:0]  mode;
    logic [7:0]  rep;
    logic        idle, start, stop;
    logic        ser, busy, btick, dtick;

    int tests = 0;
    int fails = 0;

    logic [31:0] m_data;
    int          m_len [32];
    int          nbusy, nticks, nerr;

    always #5 clk = ~clk;

    multi_freq_serial_ch dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .data_i       (data),
        .freq_sel_i   (fsel),
        .period_i     (period),
        .mode_i       (mode),
        .repeat_i     (rep),
        .idle_level_i (idle),
        .start_i      (start),
        .stop_i       (stop),
        .serial_o     (ser),
        .busy_o       (busy),
        .bit_tick_o   (btick),
        .done_tick_o  (dtick)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Walks the run cycle by cycle, comparing serial_o and bit_tick_o with the model.
    task automatic measure(input int max_cyc, input int stop_at, input bit perturb,
                           output int n_busy, output int n_ticks, output int n_err);
        int total, o, k, acc;
        logic exp_s, exp_t;
        total = 0;
        for (int j = 0; j < 32; j++) total += m_len[j];
        n_busy = 0; n_ticks = 0; n_err = 0;
        while (busy === 1'b1 && n_busy < max_cyc) begin
            o = n_busy % total;
            k = 0;
            acc = m_len[0];
            while (o >= acc) begin
                k++;
                acc += m_len[k];
            end
            exp_s = m_data[k];
            exp_t = (o == acc - 1);
            if (ser !== exp_s || btick !== exp_t) n_err++;
            if (btick === 1'b1) n_ticks++;
            n_busy++;
            if (perturb && n_busy == 10) begin
                data = ~data; start = 1'b1; period = '0; mode = 2'b01;
            end
            if (perturb && n_busy == 11) start = 1'b0;
            if (n_busy == stop_at) stop = 1'b1;
            tick();
        end
        stop = 1'b0;
        start = 1'b0;
    endtask

    task automatic cfg(input logic [31:0] d, input logic [63:0] fs, input logic [31:0] per,
                       input logic [1:0] md, input logic [7:0] rp, input logic il);
        data = d; fsel = fs; period = per; mode = md; rep = rp; idle = il;
        m_data = d;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0;
        cfg(32'h0, 64'h0, 32'h0, 2'b00, 8'd0, 1'b1);
        #2;
        check("rst_serial", ser, 0);
        check("rst_busy", busy, 0);
        check("rst_bit_tick", btick, 0);
        check("rst_done", dtick, 0);
        #10 rst_n = 1'b1;
        tick();
        check("idle_level_after_reset", ser, 1);

        // One-shot, uniform period 4
        cfg(32'h5555_5555, 64'h0, 32'h0000_0004, 2'b00, 8'd0, 1'b1);
        for (int j = 0; j < 32; j++) m_len[j] = 4;
        start_run();
        check("t1_first_bit", ser, 1);
        measure(1000, 0, 1'b0, nbusy, nticks, nerr);
        check("t1_busy_cycles", nbusy, 128);
        check("t1_bit_ticks", nticks, 32);
        check("t1_pattern_err", nerr, 0);
        check("t1_done", dtick, 1);
        check("t1_idle_serial", ser, 1);
        tick();
        check("t1_done_single", dtick, 0);

        // Mixed frequency with mid-run input changes
        cfg(32'h5555_5555, 64'h1111_1111_1111_1111, 32'h0000_0514, 2'b00, 8'd0, 1'b0);
        for (int j = 0; j < 32; j++) m_len[j] = (j % 2 == 0) ? 5 : 20;
        start_run();
        measure(1000, 0, 1'b1, nbusy, nticks, nerr);
        check("t2_busy_cycles", nbusy, 400);
        check("t2_bit_ticks", nticks, 32);
        check("t2_pattern_err", nerr, 0);
        check("t2_done", dtick, 1);
        tick();
        check("t2_no_restart", busy, 0);

        // Repeat 3 passes, then repeat 0 -> one pass
        cfg(32'h0000_0001, 64'h0, 32'h0000_0002, 2'b10, 8'd3, 1'b0);
        for (int j = 0; j < 32; j++) m_len[j] = 2;
        start_run();
        measure(1000, 0, 1'b0, nbusy, nticks, nerr);
        check("t3_busy_cycles", nbusy, 192);
        check("t3_bit_ticks", nticks, 96);
        check("t3_pattern_err", nerr, 0);
        check("t3_done", dtick, 1);
        cfg(32'h0000_0001, 64'h0, 32'h0000_0002, 2'b10, 8'd0, 1'b0);
        start_run();
        measure(1000, 0, 1'b0, nbusy, nticks, nerr);
        check("t3_rep0_busy_cycles", nbusy, 64);
        check("t3_rep0_pattern_err", nerr, 0);

        // Zero period acts as one cycle
        cfg(32'hA5A5_0F0F, 64'h0, 32'h0000_0000, 2'b00, 8'd0, 1'b0);
        for (int j = 0; j < 32; j++) m_len[j] = 1;
        start_run();
        measure(1000, 0, 1'b0, nbusy, nticks, nerr);
        check("t4_busy_cycles", nbusy, 32);
        check("t4_bit_ticks", nticks, 32);
        check("t4_pattern_err", nerr, 0);

        // Continuous, stopped during cycle 500 (last cycle of a bit)
        cfg(32'h5555_5555, 64'h0, 32'h0000_0004, 2'b01, 8'd0, 1'b1);
        for (int j = 0; j < 32; j++) m_len[j] = 4;
        start_run();
        measure(600, 500, 1'b0, nbusy, nticks, nerr);
        check("t5_busy_cycles", nbusy, 500);
        check("t5_pattern_err", nerr, 0);
        check("t5_stop_serial", ser, 1);
        check("t5_stop_busy", busy, 0);
        check("t5_stop_done", dtick, 1);
        check("t5_stop_no_tick", btick, 0);
        tick();
        check("t5_done_single", dtick, 0);

        // stop and start together in IDLE
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check("t5_idle_stop_busy", busy, 0);
        check("t5_idle_stop_done", dtick, 0);
        tick();
        check("t5_idle_stays", busy, 0);

        // Asynchronous reset mid-run, then fresh run from bit 0
        cfg(32'hFFFF_FFFF, 64'h0, 32'h0000_0004, 2'b00, 8'd0, 1'b1);
        start_run();
        repeat (49) tick();
        check("t6_running_serial", ser, 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_serial", ser, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_tick", btick, 0);
        check("t6_rst_done", dtick, 0);
        tick();
        rst_n = 1'b1;
        tick();
        cfg(32'h5555_5555, 64'h0, 32'h0000_0001, 2'b00, 8'd0, 1'b0);
        for (int j = 0; j < 32; j++) m_len[j] = 1;
        start_run();
        measure(1000, 0, 1'b0, nbusy, nticks, nerr);
        check("t6_busy_cycles", nbusy, 32);
        check("t6_pattern_err", nerr, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
